ring_monitor: RTL and testbench
===============================

// Module: ring_monitor
// PURPOSE
//  Sits directly downstream of the ring counter. Consumes its one-hot state q and the shared enable.
//  Checks that q is one-hot and advances one position per enabled cycle.
//  Encodes the active position as a binary phase and counts full revolutions.
//  Raises a sticky fault on any sequencing error.
// PARAMETERS
//  N        8   ring width; must match the ring counter's N (>=2)
//  REV_W    16  width of the revolution counter
//  LOCK_CYC 2   consecutive consistent checks needed to reach LOCKED (>=1)
// PORTS
//  clk          in   1            system clock; all state updates on posedge
//  reset        in   1            synchronous, active-low (0 = reset at next posedge)
//  en           in   1            same enable that drives the ring counter
//  q            in   N            ring counter state; rotates left (bit i -> i+1, bit N-1 -> bit 0)
//  clear_fault  in   1            leave FAULT and return to SYNC
//  locked       out  1            high in LOCKED
//  fault        out  1            high in FAULT
//  fault_code   out  2            00 none, 01 not one-hot, 10 stall, 11 wrong position
//  phase        out  clog2(N)     index of the set bit of q while LOCKED, else 0
//  rev_count    out  REV_W        completed revolutions observed while LOCKED
// BEHAVIOUR
//  - All outputs are registered.
//  - Each output reflects the q/en sampled at posedge k, visible after posedge k.
//  - Internal registers: q_prev, en_prev (sampled every edge); ok_cnt; state in {SYNC, LOCKED, FAULT}.
//  - onehot(x): exactly one bit of x is set.
//  - expected = en_prev ? rotl(q_prev, 1) : q_prev.
//  - consistent = onehot(q) && onehot(q_prev) && q == expected.
//  - Reset (reset==0 at posedge):
//      state=SYNC, ok_cnt=0, q_prev=0, en_prev=0.
//      locked=0, fault=0, fault_code=00, phase=0, rev_count=0.
//  - Reset has priority over everything.
//  SYNC:
//    - consistent: ok_cnt++.
//    - not consistent: ok_cnt=0.
//    - When ok_cnt would reach LOCK_CYC: go to LOCKED, ok_cnt=0, locked=1, phase=index(q) on the same edge.
//    - No faults are raised in SYNC.
//  LOCKED:
//    - Each edge: phase=index(q).
//    - q==rotl(q_prev,1) && q_prev[N-1] && en_prev: rev_count++ (wraps modulo 2^REV_W).
//    - !onehot(q): FAULT, code 01.
//    - else en_prev && q==q_prev: FAULT, code 10.
//    - else q != expected: FAULT, code 11 (includes moves while en_prev==0).
//    - Check priority: 01 > 10 > 11.
//    - en low: q must hold; no fault; phase and rev_count held.
//  FAULT:
//    - fault=1; locked=0; phase=0.
//    - fault_code and rev_count frozen.
//    - Further errors are ignored.
//    - clear_fault=1: next edge goes to SYNC, fault=0, code=00, ok_cnt=0; rev_count kept.
//  Simultaneous events:
//    - clear_fault in non-FAULT states: no effect.
//    - Error and wrap on the same edge: fault wins, rev_count not incremented.
//  Reset mid-operation: from any state, clears everything on that edge, exactly as at power-up.
// TESTING
//  1. reset=0 for 10 cycles, q random -> locked=0, fault=0, fault_code=00, phase=0, rev_count=0.
//  2. N=8, LOCK_CYC=2; q=8'h01 with en=0 for 3 cycles -> locked=1 after 2 consistent checks, phase=0.
//  3. From lock at phase 0, en=1 for 100 cycles with correct rotation:
//       phase cycles 0..7, fault stays 0, rev_count=12 at end.
//  4. While LOCKED, force q=8'b0000_0101 -> next edge fault=1, fault_code=01, locked=0, rev_count frozen;
//       clear_fault=1 -> SYNC, then relocks after 2 good checks.
//  5. en_prev=1 with q held -> code 10; rotate by 2 positions -> code 11;
//       en=0 with q held -> no fault.
//  6. reset=0 on the same edge as a fault condition and clear_fault=1 -> all outputs at reset values next edge.

Source files
------------

// File: rtl/ring_monitor.sv
// ring_monitor: watches a left-rotating one-hot ring counter and its enable.
// It checks that the ring stays one-hot and advances once per enabled cycle,
// reports the active position as a binary phase, counts full revolutions,
// and latches a sticky fault with a cause code on the first sequencing error.
// Ports:
//   clk          system clock, all state changes on posedge
//   reset        synchronous active-low reset
//   en           enable shared with the ring counter
//   q            ring counter state (bit i -> i+1, bit N-1 -> bit 0)
//   clear_fault  leave FAULT and resynchronise
//   locked       high while LOCKED
//   fault        high while FAULT
//   fault_code   00 none, 01 not one-hot, 10 stall, 11 wrong position
//   phase        index of the set bit of q while LOCKED, else 0
//   rev_count    completed revolutions seen while LOCKED (wraps)
module ring_monitor #(
  parameter int unsigned N        = 8,
  parameter int unsigned REV_W    = 16,
  parameter int unsigned LOCK_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         q,
  input  logic                 clear_fault,
  output logic                 locked,
  output logic                 fault,
  output logic [1:0]           fault_code,
  output logic [$clog2(N)-1:0] phase,
  output logic [REV_W-1:0]     rev_count
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned CW = $clog2(LOCK_CYC + 1);

  typedef enum logic [1:0] {SYNC, LOCKED, FAULT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ok_cnt_q, ok_cnt_d;
  logic [N-1:0]    q_prev;
  logic            en_prev;
  logic            locked_d, fault_d;
  logic [1:0]      code_d;
  logic [PW-1:0]   phase_d;
  logic [REV_W-1:0] rev_d;

  function automatic logic is_onehot(input logic [N-1:0] x);
    return (x != '0) && ((x & (x - N'(1))) == '0);
  endfunction

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] x);
    return {x[N-2:0], x[N-1]};
  endfunction

  // Binary index of the set bit; only meaningful when x is one-hot.
  function automatic logic [PW-1:0] index_of(input logic [N-1:0] x);
    logic [PW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (x[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  logic [N-1:0] expected_c;
  logic         oh_q_c, consistent_c, wrap_c;

  always_comb begin
    expected_c   = en_prev ? rotl1(q_prev) : q_prev;
    oh_q_c       = is_onehot(q);
    consistent_c = oh_q_c && is_onehot(q_prev) && (q == expected_c);
    wrap_c       = en_prev && q_prev[N-1] && (q == rotl1(q_prev));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ok_cnt_d = ok_cnt_q;
    locked_d = locked;
    fault_d  = fault;
    code_d   = fault_code;
    phase_d  = phase;
    rev_d    = rev_count;
    case (state_q)
      SYNC: begin
        locked_d = 1'b0;
        fault_d  = 1'b0;
        code_d   = 2'b00;
        phase_d  = '0;
        if (consistent_c) begin
          if (ok_cnt_q == CW'(LOCK_CYC - 1)) begin
            state_d  = LOCKED;
            ok_cnt_d = '0;
            locked_d = 1'b1;
            phase_d  = index_of(q);
          end else begin
            ok_cnt_d = ok_cnt_q + CW'(1);
          end
        end else begin
          ok_cnt_d = '0;
        end
      end
      LOCKED: begin
        // Error checks in priority order; a fault suppresses any wrap count.
        if (!oh_q_c || (en_prev && q == q_prev) || (q != expected_c)) begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          locked_d = 1'b0;
          phase_d  = '0;
          if (!oh_q_c)                  code_d = 2'b01;
          else if (en_prev && q == q_prev) code_d = 2'b10;
          else                          code_d = 2'b11;
        end else begin
          phase_d = index_of(q);
          if (wrap_c) rev_d = rev_count + REV_W'(1);
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d  = SYNC;
          fault_d  = 1'b0;
          code_d   = 2'b00;
          ok_cnt_d = '0;
        end
      end
      default: begin
        state_d  = SYNC;
        ok_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= SYNC;
      ok_cnt_q   <= '0;
      q_prev     <= '0;
      en_prev    <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      phase      <= '0;
      rev_count  <= '0;
    end else begin
      state_q    <= state_d;
      ok_cnt_q   <= ok_cnt_d;
      q_prev     <= q;
      en_prev    <= en;
      locked     <= locked_d;
      fault      <= fault_d;
      fault_code <= code_d;
      phase      <= phase_d;
      rev_count  <= rev_d;
    end
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor (N=8, REV_W=16, LOCK_CYC=2).
module tb_ring_monitor;

  logic        clk = 1'b0;
  logic        reset, en, clear_fault;
  logic [7:0]  q;
  logic        locked, fault;
  logic [1:0]  fault_code;
  logic [2:0]  phase;
  logic [15:0] rev_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_monitor #(.N(8), .REV_W(16), .LOCK_CYC(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .q           (q),
    .clear_fault (clear_fault),
    .locked      (locked),
    .fault       (fault),
    .fault_code  (fault_code),
    .phase       (phase),
    .rev_count   (rev_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic lk, input logic flt,
                            input logic [1:0] code, input logic [2:0] ph, input logic [15:0] rev);
    check({tag, ".locked"},     32'(locked),     32'(lk));
    check({tag, ".fault"},      32'(fault),      32'(flt));
    check({tag, ".fault_code"}, 32'(fault_code), 32'(code));
    check({tag, ".phase"},      32'(phase),      32'(ph));
    check({tag, ".rev_count"},  32'(rev_count),  32'(rev));
  endtask

  // Apply one set of inputs across one posedge; outputs sampled 1ns later.
  task automatic cyc(input logic [7:0] qv, input logic ev, input logic cf, input logic rv);
    q = qv; en = ev; clear_fault = cf; reset = rv;
    @(posedge clk);
    #1;
  endtask

  // Clear a fault and relock at q=01 (clear edge + two consistent checks).
  task automatic relock(input string tag, input logic [15:0] rev);
    cyc(8'h01, 1'b0, 1'b1, 1'b1);
    expect_out({tag, ".cleared"}, 1'b0, 1'b0, 2'b00, 3'd0, rev);
    cyc(8'h01, 1'b0, 1'b0, 1'b1);
    cyc(8'h01, 1'b0, 1'b0, 1'b1);
    expect_out({tag, ".relocked"}, 1'b1, 1'b0, 2'b00, 3'd0, rev);
  endtask

  logic [7:0] r;

  initial begin
    reset = 1'b0; en = 1'b0; q = 8'h00; clear_fault = 1'b0;
    #2;

    // 1: held in reset with random inputs
    for (int i = 0; i < 10; i++) begin
      cyc(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      expect_out("reset", 1'b0, 1'b0, 2'b00, 3'd0, 16'd0);
    end

    // 2: lock on a held ring
    cyc(8'h01, 1'b0, 1'b0, 1'b1);
    check("lock.e1", 32'(locked), 32'd0);
    cyc(8'h01, 1'b0, 1'b0, 1'b1);
    check("lock.e2", 32'(locked), 32'd0);
    cyc(8'h01, 1'b0, 1'b0, 1'b1);
    expect_out("lock.e3", 1'b1, 1'b0, 2'b00, 3'd0, 16'd0);

    // 3: 100 enabled cycles of correct rotation
    r = 8'h01;
    for (int k = 1; k <= 100; k++) begin
      cyc(r, 1'b1, 1'b0, 1'b1);
      r = {r[6:0], r[7]};
      check($sformatf("rot.phase%0d", k), 32'(phase), 32'((k - 1) % 8));
      check($sformatf("rot.fault%0d", k), 32'(fault), 32'd0);
    end
    expect_out("rot.end", 1'b1, 1'b0, 2'b00, 3'd3, 16'd12);

    // 4: not one-hot, fault is sticky, then clear and relock
    cyc(8'h05, 1'b1, 1'b0, 1'b1);
    expect_out("nonhot", 1'b0, 1'b1, 2'b01, 3'd0, 16'd12);
    cyc(8'hff, 1'b1, 1'b0, 1'b1);
    expect_out("sticky", 1'b0, 1'b1, 2'b01, 3'd0, 16'd12);
    relock("clr1", 16'd12);

    // 5a: stall while enabled
    cyc(8'h01, 1'b1, 1'b0, 1'b1);
    expect_out("pre_stall", 1'b1, 1'b0, 2'b00, 3'd0, 16'd12);
    cyc(8'h01, 1'b1, 1'b0, 1'b1);
    expect_out("stall", 1'b0, 1'b1, 2'b10, 3'd0, 16'd12);
    relock("clr2", 16'd12);

    // 5b: skip by two positions
    cyc(8'h01, 1'b1, 1'b0, 1'b1);
    cyc(8'h04, 1'b1, 1'b0, 1'b1);
    expect_out("skip", 1'b0, 1'b1, 2'b11, 3'd0, 16'd12);
    relock("clr3", 16'd12);

    // 5c: hold with en low is fine; clear_fault while locked does nothing
    for (int i = 0; i < 4; i++) begin
      cyc(8'h01, 1'b0, 1'b1, 1'b1);
      expect_out($sformatf("hold%0d", i), 1'b1, 1'b0, 2'b00, 3'd0, 16'd12);
    end

    // 5d: move while en was low
    cyc(8'h01, 1'b0, 1'b0, 1'b1);
    cyc(8'h02, 1'b0, 1'b0, 1'b1);
    expect_out("move_no_en", 1'b0, 1'b1, 2'b11, 3'd0, 16'd12);
    relock("clr4", 16'd12);

    // Error coinciding with a wrap: fault wins, no revolution counted
    r = 8'h01;
    for (int k = 0; k < 8; k++) begin
      cyc(r, 1'b1, 1'b0, 1'b1);
      r = {r[6:0], r[7]};
    end
    expect_out("pre_wrap", 1'b1, 1'b0, 2'b00, 3'd7, 16'd12);
    cyc(8'h03, 1'b1, 1'b0, 1'b1);
    expect_out("wrap_err", 1'b0, 1'b1, 2'b01, 3'd0, 16'd12);
    relock("clr5", 16'd12);

    // 6: reset coinciding with a fault condition and clear_fault
    cyc(8'h05, 1'b1, 1'b1, 1'b0);
    expect_out("rst_mid", 1'b0, 1'b0, 2'b00, 3'd0, 16'd0);
    cyc(8'h01, 1'b0, 1'b0, 1'b1);
    expect_out("post_rst", 1'b0, 1'b0, 2'b00, 3'd0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
